instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter NOP_INSTRUCTION, default 32'h0000_0013, which is the instruction word presented when no valid instruction is held.
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port pc, input, 32 bits: current PC from the program counter register.
REQ-005 SHALL have port pc_write_enable, output, 1 bit: write enable to the program counter register.
REQ-006 SHALL have ports imem_req_valid (output, 1), imem_req_ready (input, 1) and imem_req_address (output, 32): the instruction memory request channel.
REQ-007 SHALL have ports imem_resp_valid (input, 1) and imem_resp_data (input, 32): the instruction memory response, one beat per accepted request.
REQ-008 SHALL have ports redirect (input, 1): branch/jump/trap taken; next_pc already holds the target.
REQ-009 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_instruction (output, 32), out_pc (output, 32) and out_misaligned (output, 1): the decode-side channel.

Function
REQ-010 SHALL implement states REQUEST, WAIT_RESP, HOLD and DISCARD, with at most one memory request outstanding.
REQ-011 SHALL drive imem_req_address = {pc[31:2], 2'b00} combinationally.
REQ-012 SHALL assert imem_req_valid when all of the following hold: redirect=0, pc[1:0]=0, and either state=REQUEST or (state=HOLD and out_ready=1).
REQ-013 SHALL define fire = imem_req_valid & imem_req_ready, and SHALL drive pc_write_enable = fire | redirect.
REQ-014 On fire, SHALL capture pc into an internal request-PC register and go to WAIT_RESP.
REQ-015 In REQUEST with redirect=0 and pc[1:0]!=0, SHALL issue no request, load out_pc=pc, out_instruction=NOP_INSTRUCTION, out_misaligned=1 and out_valid=1, go to HOLD, and leave pc_write_enable low.
REQ-016 In WAIT_RESP with imem_resp_valid=1 and redirect=0, SHALL load out_instruction=imem_resp_data, out_pc=request PC, out_misaligned=0 and out_valid=1, and go to HOLD; response-to-output latency is 1 cycle.
REQ-017 In HOLD, outputs SHALL stay stable until out_ready=1.
REQ-018 In HOLD with out_ready=1, SHALL clear out_valid, then go to WAIT_RESP if fire occurred, otherwise to REQUEST.
REQ-019 Redirect in REQUEST SHALL leave the state in REQUEST.
REQ-020 Redirect in HOLD SHALL clear out_valid and go to REQUEST; the held instruction is never delivered.
REQ-021 Redirect in WAIT_RESP SHALL go to REQUEST if imem_resp_valid=1 in the same cycle (response dropped), otherwise to DISCARD.
REQ-022 In DISCARD, SHALL ignore and drop the next imem_resp_valid beat and then go to REQUEST; redirect while in DISCARD SHALL keep the state in DISCARD.
REQ-023 imem_resp_valid in REQUEST or HOLD SHALL be ignored and SHALL be flagged by a simulation-only assertion.
REQ-024 pc_write_enable SHALL never be asserted for a misaligned pc without redirect.

Reset
REQ-025 On reset=1 at a clock edge, SHALL set state=REQUEST, out_valid=0, out_instruction=NOP_INSTRUCTION, out_pc=0, out_misaligned=0 and request-PC=0.
REQ-026 Reset SHALL take priority over redirect and all handshakes; any in-flight request is abandoned, and instruction memory is reset by the same reset.
REQ-027 While reset=1, imem_req_valid and pc_write_enable SHALL be 0.

Structure
REQ-028 The NOP constant and the fetch state encoding SHALL live in the shared configuration/constants package next to INITIAL_PC.
REQ-029 SHALL be a single module with no sub-modules; the output holding register is inline.

Verification
REQ-030 Bench SHALL cover this case: pc=0x0000_0000, imem ready, response 0x0010_0093 one cycle after the request, out_ready=1. Required response: pc_write_enable pulses once, out_valid rises with out_pc=0, out_instruction=0x0010_0093, out_misaligned=0.
REQ-031 Bench SHALL cover this case: instruction in HOLD, out_ready=0 for 3 cycles. Required response: out_valid, out_pc and out_instruction are stable for all 3 cycles, and no request is issued.
REQ-032 Bench SHALL cover this case: redirect in WAIT_RESP, response arrives 2 cycles later with 0xDEAD_BEEF. Required response: state goes to DISCARD, 0xDEAD_BEEF never appears on out_valid=1, and the next request uses the redirected pc.
REQ-033 Bench SHALL cover this case: pc=0x0000_0102 in REQUEST. Required response: no imem_req_valid, out_valid=1 with out_misaligned=1, out_pc=0x0000_0102 and out_instruction=0x0000_0013.
REQ-034 Bench SHALL cover this case: reset asserted in HOLD with out_valid=1. Required response: after the edge, out_valid=0, out_pc=0 and state=REQUEST.
REQ-035 Bench SHALL cover this case: HOLD with out_ready=1 and imem_req_ready=1 in the same cycle. Required response: back-to-back fetch with no idle cycle, and pc_write_enable high in that cycle.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Purpose: shared fetch constants (reset PC, NOP word) and fetch FSM state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package instruction_fetch_pkg;

   localparam logic [31:0] INITIAL_PC            = 32'h0000_0000;
   localparam logic [31:0] FETCH_NOP_INSTRUCTION = 32'h0000_0013;

   typedef enum logic [1:0] {
      FETCH_REQUEST   = 2'd0,
      FETCH_WAIT_RESP = 2'd1,
      FETCH_HOLD      = 2'd2,
      FETCH_DISCARD   = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/instruction_fetch.sv
// Purpose: single-outstanding instruction fetch with an inline output holding register.
// Latency: imem response to out_valid is 1 cycle; held output may refetch back-to-back.
// Backpressure: out_ready low holds the output stable and blocks new requests; imem_req_ready stalls requests.
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter logic [31:0] NOP_INSTRUCTION = FETCH_NOP_INSTRUCTION
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] pc,
   output logic        pc_write_enable,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_address,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        redirect,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instruction,
   output logic [31:0] out_pc,
   output logic        out_misaligned
);

   fetch_state_t state_q, state_d;
   logic         out_valid_q, out_valid_d;
   logic [31:0]  out_instruction_q, out_instruction_d;
   logic [31:0]  out_pc_q, out_pc_d;
   logic         out_misaligned_q, out_misaligned_d;
   logic [31:0]  req_pc_q, req_pc_d;

   logic pc_aligned;
   logic fire;

   // Request channel: only issue when the output slot is (or is about to be) free and the PC is aligned.
   always_comb begin
      pc_aligned       = (pc[1:0] == 2'b00);
      imem_req_address = {pc[31:2], 2'b00};
      imem_req_valid   = !reset && !redirect && pc_aligned &&
                         ((state_q == FETCH_REQUEST) || ((state_q == FETCH_HOLD) && out_ready));
      fire             = imem_req_valid && imem_req_ready;
      pc_write_enable  = !reset && (fire || redirect);
   end

   // Next-state and holding-register update.
   always_comb begin
      state_d           = state_q;
      out_valid_d       = out_valid_q;
      out_instruction_d = out_instruction_q;
      out_pc_d          = out_pc_q;
      out_misaligned_d  = out_misaligned_q;
      req_pc_d          = req_pc_q;
      unique case (state_q)
         FETCH_REQUEST: begin
            if (!redirect) begin
               if (fire) begin
                  req_pc_d = pc;
                  state_d  = FETCH_WAIT_RESP;
               end else if (!pc_aligned) begin
                  // Misaligned PC becomes a flagged NOP so decode can raise the fault in order.
                  out_valid_d       = 1'b1;
                  out_instruction_d = NOP_INSTRUCTION;
                  out_pc_d          = pc;
                  out_misaligned_d  = 1'b1;
                  state_d           = FETCH_HOLD;
               end
            end
         end
         FETCH_WAIT_RESP: begin
            if (redirect) begin
               // A same-cycle response is simply dropped; otherwise the late beat must be swallowed.
               state_d = imem_resp_valid ? FETCH_REQUEST : FETCH_DISCARD;
            end else if (imem_resp_valid) begin
               out_valid_d       = 1'b1;
               out_instruction_d = imem_resp_data;
               out_pc_d          = req_pc_q;
               out_misaligned_d  = 1'b0;
               state_d           = FETCH_HOLD;
            end
         end
         FETCH_HOLD: begin
            if (redirect) begin
               out_valid_d = 1'b0;
               state_d     = FETCH_REQUEST;
            end else if (out_ready) begin
               out_valid_d = 1'b0;
               if (fire) begin
                  req_pc_d = pc;
                  state_d  = FETCH_WAIT_RESP;
               end else begin
                  state_d = FETCH_REQUEST;
               end
            end
         end
         FETCH_DISCARD: begin
            // The stale beat is consumed even if another redirect lands in the same cycle,
            // since no further beat is owed and waiting would deadlock.
            if (imem_resp_valid) begin
               state_d = FETCH_REQUEST;
            end
         end
         default: state_d = FETCH_REQUEST;
      endcase
   end

   // State and holding-register flops with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q           <= FETCH_REQUEST;
         out_valid_q       <= 1'b0;
         out_instruction_q <= NOP_INSTRUCTION;
         out_pc_q          <= 32'h0;
         out_misaligned_q  <= 1'b0;
         req_pc_q          <= 32'h0;
      end else begin
         state_q           <= state_d;
         out_valid_q       <= out_valid_d;
         out_instruction_q <= out_instruction_d;
         out_pc_q          <= out_pc_d;
         out_misaligned_q  <= out_misaligned_d;
         req_pc_q          <= req_pc_d;
      end
   end

   assign out_valid       = out_valid_q;
   assign out_instruction = out_instruction_q;
   assign out_pc          = out_pc_q;
   assign out_misaligned  = out_misaligned_q;

   // A response is only legal while a request is outstanding or being discarded.
   a_resp_only_when_expected: assert property (@(posedge clock) disable iff (reset)
      imem_resp_valid |-> ((state_q == FETCH_WAIT_RESP) || (state_q == FETCH_DISCARD)))
      else $error("imem response while no request outstanding");

   // The PC register must never advance past a misaligned PC on its own.
   a_no_misaligned_advance: assert property (@(posedge clock) disable iff (reset)
      (pc_write_enable && !redirect) |-> (pc[1:0] == 2'b00))
      else $error("pc_write_enable on misaligned pc");

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
   import instruction_fetch_pkg::*;

   logic        clock;
   logic        reset;
   logic [31:0] pc;
   logic        pc_write_enable;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_address;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        redirect;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instruction;
   logic [31:0] out_pc;
   logic        out_misaligned;

   int n_checks = 0;
   int n_fail   = 0;
   int leak_cnt = 0;

   localparam logic [31:0] NOP = 32'h0000_0013;

   instruction_fetch dut (
      .clock            (clock),
      .reset            (reset),
      .pc               (pc),
      .pc_write_enable  (pc_write_enable),
      .imem_req_valid   (imem_req_valid),
      .imem_req_ready   (imem_req_ready),
      .imem_req_address (imem_req_address),
      .imem_resp_valid  (imem_resp_valid),
      .imem_resp_data   (imem_resp_data),
      .redirect         (redirect),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_instruction  (out_instruction),
      .out_pc           (out_pc),
      .out_misaligned   (out_misaligned)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Watch for the discarded word ever being presented as valid.
   always @(negedge clock) begin
      if (out_valid && out_instruction == 32'hDEAD_BEEF) leak_cnt++;
   end

   typedef struct {
      logic        rst;
      logic [31:0] pc;
      logic        redir;
      logic        rq_rdy;
      logic        rsp_vld;
      logic [31:0] rsp_dat;
      logic        o_rdy;
      logic        e_req;
      logic        e_we;
      logic        e_vld;
      logic [31:0] e_ins;
      logic [31:0] e_pc;
      logic        e_mis;
   } vec_t;

   vec_t vecs[$];

   task automatic add_vec(input logic rst, input logic [31:0] p, input logic redir,
                          input logic rq_rdy, input logic rsp_vld, input logic [31:0] rsp_dat,
                          input logic o_rdy, input logic e_req, input logic e_we,
                          input logic e_vld, input logic [31:0] e_ins, input logic [31:0] e_pc,
                          input logic e_mis);
      vec_t v;
      v.rst = rst; v.pc = p; v.redir = redir; v.rq_rdy = rq_rdy; v.rsp_vld = rsp_vld;
      v.rsp_dat = rsp_dat; v.o_rdy = o_rdy; v.e_req = e_req; v.e_we = e_we;
      v.e_vld = e_vld; v.e_ins = e_ins; v.e_pc = e_pc; v.e_mis = e_mis;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic rst, input logic [31:0] p, input logic redir,
                        input logic rq_rdy, input logic rsp_vld, input logic [31:0] rsp_dat,
                        input logic o_rdy);
      @(negedge clock);
      reset = rst; pc = p; redirect = redir; imem_req_ready = rq_rdy;
      imem_resp_valid = rsp_vld; imem_resp_data = rsp_dat; out_ready = o_rdy;
      #1;
   endtask

   initial begin
      reset = 1'b1; pc = 32'h0; redirect = 1'b0; imem_req_ready = 1'b0;
      imem_resp_valid = 1'b0; imem_resp_data = 32'h0; out_ready = 1'b0;
      repeat (2) @(posedge clock);

      //       rst pc            rd rq rv dat            ordy | req we vld ins            opc           mis
      add_vec(1, 32'h0000_0000, 0, 0, 0, 32'h0,          0,    0,  0, 0,  NOP,           32'h0,        0);
      add_vec(0, 32'h0000_0000, 0, 1, 0, 32'h0,          1,    1,  1, 0,  NOP,           32'h0,        0);
      add_vec(0, 32'h0000_0004, 0, 1, 1, 32'h0010_0093,  1,    0,  0, 0,  NOP,           32'h0,        0);
      add_vec(0, 32'h0000_0004, 0, 1, 0, 32'h0,          1,    1,  1, 1,  32'h0010_0093, 32'h0,        0);
      add_vec(0, 32'h0000_0008, 0, 1, 1, 32'h0020_0113,  0,    0,  0, 0,  32'h0010_0093, 32'h0,        0);
      add_vec(0, 32'h0000_0008, 0, 1, 0, 32'h0,          0,    0,  0, 1,  32'h0020_0113, 32'h4,        0);
      add_vec(0, 32'h0000_0008, 0, 0, 0, 32'h0,          1,    1,  0, 1,  32'h0020_0113, 32'h4,        0);
      add_vec(0, 32'h0000_0102, 0, 1, 0, 32'h0,          0,    0,  0, 0,  32'h0020_0113, 32'h4,        0);
      add_vec(0, 32'h0000_0102, 0, 1, 0, 32'h0,          0,    0,  0, 1,  NOP,           32'h102,      1);
      add_vec(0, 32'h0000_0200, 1, 1, 0, 32'h0,          0,    0,  1, 1,  NOP,           32'h102,      1);
      add_vec(0, 32'h0000_0200, 0, 0, 0, 32'h0,          0,    1,  0, 0,  NOP,           32'h102,      1);
      add_vec(0, 32'h0000_0200, 0, 1, 0, 32'h0,          0,    1,  1, 0,  NOP,           32'h102,      1);
      add_vec(0, 32'h0000_0204, 0, 0, 0, 32'h0,          1,    0,  0, 0,  NOP,           32'h102,      1);
      add_vec(0, 32'h0000_0204, 0, 0, 1, 32'h0030_0193,  1,    0,  0, 0,  NOP,           32'h102,      1);
      add_vec(0, 32'h0000_0204, 0, 0, 0, 32'h0,          1,    1,  0, 1,  32'h0030_0193, 32'h200,      0);

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].pc, vecs[i].redir, vecs[i].rq_rdy,
               vecs[i].rsp_vld, vecs[i].rsp_dat, vecs[i].o_rdy);
         chk($sformatf("v%0d req_vld", i), 32'(imem_req_valid), 32'(vecs[i].e_req));
         chk($sformatf("v%0d pc_we", i), 32'(pc_write_enable), 32'(vecs[i].e_we));
         chk($sformatf("v%0d out_vld", i), 32'(out_valid), 32'(vecs[i].e_vld));
         chk($sformatf("v%0d out_ins", i), out_instruction, vecs[i].e_ins);
         chk($sformatf("v%0d out_pc", i), out_pc, vecs[i].e_pc);
         chk($sformatf("v%0d out_mis", i), 32'(out_misaligned), 32'(vecs[i].e_mis));
         chk($sformatf("v%0d req_addr", i), imem_req_address, {vecs[i].pc[31:2], 2'b00});
      end

      // Hold with out_ready low for 3 cycles: output stable, no request.
      drive(0, 32'h0000_0204, 0, 1, 0, 32'h0, 0);
      chk("hold fire", 32'(pc_write_enable), 32'd1);
      drive(0, 32'h0000_0208, 0, 1, 1, 32'h0040_0213, 0);
      for (int c = 0; c < 3; c++) begin
         drive(0, 32'h0000_0208, 0, 1, 0, 32'h0, 0);
         chk($sformatf("hold%0d vld", c), 32'(out_valid), 32'd1);
         chk($sformatf("hold%0d pc", c), out_pc, 32'h0000_0204);
         chk($sformatf("hold%0d ins", c), out_instruction, 32'h0040_0213);
         chk($sformatf("hold%0d req", c), 32'(imem_req_valid), 32'd0);
      end
      drive(0, 32'h0000_0208, 0, 0, 0, 32'h0, 1);

      // Redirect in WAIT_RESP, stale response two cycles later is discarded.
      drive(0, 32'h0000_0208, 0, 1, 0, 32'h0, 1);
      chk("disc fire", 32'(pc_write_enable), 32'd1);
      drive(0, 32'h0000_0300, 1, 1, 0, 32'h0, 1);
      chk("disc redir we", 32'(pc_write_enable), 32'd1);
      chk("disc redir req", 32'(imem_req_valid), 32'd0);
      drive(0, 32'h0000_0300, 0, 1, 0, 32'h0, 1);
      chk("disc state", 32'(dut.state_q), 32'(FETCH_DISCARD));
      chk("disc req", 32'(imem_req_valid), 32'd0);
      drive(0, 32'h0000_0300, 0, 1, 1, 32'hDEAD_BEEF, 1);
      chk("disc beat req", 32'(imem_req_valid), 32'd0);
      drive(0, 32'h0000_0300, 0, 1, 0, 32'h0, 1);
      chk("after disc req", 32'(imem_req_valid), 32'd1);
      chk("after disc addr", imem_req_address, 32'h0000_0300);
      chk("after disc out_vld", 32'(out_valid), 32'd0);
      drive(0, 32'h0000_0304, 0, 0, 1, 32'h0050_0293, 0);
      drive(0, 32'h0000_0304, 0, 0, 0, 32'h0, 0);
      chk("redir fetch vld", 32'(out_valid), 32'd1);
      chk("redir fetch ins", out_instruction, 32'h0050_0293);
      chk("redir fetch pc", out_pc, 32'h0000_0300);

      // Reset while holding a valid instruction.
      drive(1, 32'h0000_0304, 0, 1, 0, 32'h0, 1);
      chk("rst req", 32'(imem_req_valid), 32'd0);
      chk("rst we", 32'(pc_write_enable), 32'd0);
      drive(1, 32'h0000_0304, 1, 1, 0, 32'h0, 1);
      chk("rst redir we", 32'(pc_write_enable), 32'd0);
      chk("rst out_vld", 32'(out_valid), 32'd0);
      chk("rst out_pc", out_pc, 32'h0);
      chk("rst out_ins", out_instruction, NOP);
      chk("rst out_mis", 32'(out_misaligned), 32'd0);
      chk("rst state", 32'(dut.state_q), 32'(FETCH_REQUEST));
      drive(0, 32'h0000_0000, 0, 0, 0, 32'h0, 0);
      chk("post rst req", 32'(imem_req_valid), 32'd1);

      chk("deadbeef leak", 32'(leak_cnt), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
